// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings
// and the sequential increment.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_JR     = 2'b11
    } pc_sel_e;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control and address bundle between the fetch controller (master) and the
// program-counter unit (slave).
interface pc_unit_if #(
    parameter int XLEN = 32
) ();

    logic               stall;
    pc_pkg::pc_sel_e    pc_mux_sel;
    logic               branch_taken;
    logic [XLEN-1:0]    imm_offset;
    logic [25:0]        jump_index;
    logic [XLEN-1:0]    jr_target;
    logic               ras_push;
    logic               ras_pop;

    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus_4;
    logic [XLEN-1:0]    branch_target;
    logic [XLEN-1:0]    jump_target;
    logic [XLEN-1:0]    next_pc;
    logic               ras_empty;
    logic               ras_full;
    logic               misaligned;

    modport master (
        output stall, pc_mux_sel, branch_taken, imm_offset, jump_index,
               jr_target, ras_push, ras_pop,
        input  pc, pc_plus_4, branch_target, jump_target, next_pc,
               ras_empty, ras_full, misaligned
    );

    modport slave (
        input  stall, pc_mux_sel, branch_taken, imm_offset, jump_index,
               jr_target, ras_push, ras_pop,
        output pc, pc_plus_4, branch_target, jump_target, next_pc,
               ras_empty, ras_full, misaligned
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; when full, a push silently overwrites the
// oldest entry so deep call chains lose their outermost return first.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(RAS_DEPTH));
    assign top   = entries[ptr];

    // A call and return in the same cycle swaps the top in place.
    assign do_replace = push && pop && !empty;
    assign do_push    = push && !do_replace;
    assign do_pop     = pop && !push && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (do_pop) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            entries[ptr + PTR_W'(1)] <= din;
        else if (do_replace)
            entries[ptr] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential, branch, jump and register-jump sources,
// plus a return-address stack that can short-circuit register jumps.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_push;
    logic            ras_pop;

    assign pc_plus_4     = pc_q + XLEN'(PC_INCR);
    assign branch_target = pc_plus_4 + (bus.imm_offset << 2);
    assign jump_target   = {pc_plus_4[XLEN-1:28], bus.jump_index, 2'b00};

    always_comb begin
        raw_target = pc_plus_4;
        case (bus.pc_mux_sel)
            SEL_SEQ:    raw_target = pc_plus_4;
            SEL_BRANCH: raw_target = bus.branch_taken ? branch_target : pc_plus_4;
            SEL_JUMP:   raw_target = jump_target;
            SEL_JR:     raw_target = (bus.ras_pop && !ras_empty) ? ras_top : bus.jr_target;
            default:    raw_target = pc_plus_4;
        endcase
    end

    // Low address bits are cleared rather than trapped; misaligned lets the
    // core raise the exception itself.
    assign next_pc = {raw_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= RESET_VECTOR;
        else if (!bus.stall)
            pc_q <= next_pc;
    end

    assign ras_push = bus.ras_push && !bus.stall;
    assign ras_pop  = bus.ras_pop && (bus.pc_mux_sel == SEL_JR) && !bus.stall;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus_4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    assign bus.pc            = pc_q;
    assign bus.pc_plus_4     = pc_plus_4;
    assign bus.branch_target = branch_target;
    assign bus.jump_target   = jump_target;
    assign bus.next_pc       = next_pc;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.misaligned    = |raw_target[1:0];

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected values tagged with
// the cycle they must appear in; a negedge monitor pops and compares them.
module tb_pc_unit;
    import pc_pkg::*;

    localparam logic [31:0] RV = 32'h0040_0000;

    typedef enum int {K_PC, K_PC4, K_BT, K_JT, K_NPC, K_EMPTY, K_FULL, K_MIS} kind_e;

    typedef struct {
        kind_e       kind;
        int unsigned cycle;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          check_count = 0;
    int          pass_count = 0;
    exp_t        sb[$];

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string name_of(kind_e k);
        case (k)
            K_PC:    return "pc";
            K_PC4:   return "pc_plus_4";
            K_BT:    return "branch_target";
            K_JT:    return "jump_target";
            K_NPC:   return "next_pc";
            K_EMPTY: return "ras_empty";
            K_FULL:  return "ras_full";
            default: return "misaligned";
        endcase
    endfunction

    task automatic check_output(exp_t e);
        logic [31:0] actual;
        case (e.kind)
            K_PC:    actual = bus.pc;
            K_PC4:   actual = bus.pc_plus_4;
            K_BT:    actual = bus.branch_target;
            K_JT:    actual = bus.jump_target;
            K_NPC:   actual = bus.next_pc;
            K_EMPTY: actual = {31'd0, bus.ras_empty};
            K_FULL:  actual = {31'd0, bus.ras_full};
            default: actual = {31'd0, bus.misaligned};
        endcase
        check_count++;
        if (actual === e.value)
            pass_count++;
        else
            $display("[TB] FAIL %s @cycle %0d: got %h, expected %h",
                     name_of(e.kind), cyc, actual, e.value);
    endtask

    // Monitor: everything due by this cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cycle <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check_output(e);
        end
    end

    task automatic expect_at(kind_e k, int unsigned when, logic [31:0] v);
        exp_t e;
        e.kind  = k;
        e.cycle = when;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(pc_sel_e sel, logic taken, logic [31:0] imm,
                                  logic [25:0] jidx, logic [31:0] jrt,
                                  logic push, logic pop, logic stl);
        bus.pc_mux_sel   = sel;
        bus.branch_taken = taken;
        bus.imm_offset   = imm;
        bus.jump_index   = jidx;
        bus.jr_target    = jrt;
        bus.ras_push     = push;
        bus.ras_pop      = pop;
        bus.stall        = stl;
    endtask

    task automatic set_pc(logic [31:0] a);
        apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, a, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    logic [31:0] pop_seq [5] = '{32'h54, 32'h44, 32'h34, 32'h24, 32'hDEAD_BEE0};

    initial begin
        reset = 1'b1;
        apply_stimulus(SEL_SEQ, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_at(K_PC, cyc, RV);
        expect_at(K_EMPTY, cyc, 32'd1);
        expect_at(K_FULL, cyc, 32'd0);
        tick();
        reset = 1'b0;

        // Sequential fetch from the reset vector
        for (int i = 0; i < 4; i++) begin
            expect_at(K_PC, cyc, RV + 32'(4 * i));
            if (i == 0) begin
                expect_at(K_PC4, cyc, RV + 32'd4);
                expect_at(K_MIS, cyc, 32'd0);
            end
            tick();
        end

        // Branch taken backwards and not taken
        set_pc(32'h100);
        apply_stimulus(SEL_BRANCH, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        expect_at(K_BT, cyc, 32'h0FC);
        expect_at(K_NPC, cyc, 32'h0FC);
        expect_at(K_PC, cyc + 1, 32'h0FC);
        tick();
        set_pc(32'h100);
        apply_stimulus(SEL_BRANCH, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        expect_at(K_PC, cyc + 1, 32'h104);
        tick();

        // Jump keeps the upper nibble; SEQ wraps at the top of memory
        set_pc(32'h9000_0010);
        apply_stimulus(SEL_JUMP, 1'b0, 32'd0, 26'h40, 32'd0, 1'b0, 1'b0, 1'b0);
        expect_at(K_JT, cyc, 32'h9000_0100);
        expect_at(K_PC, cyc + 1, 32'h9000_0100);
        tick();
        set_pc(32'hFFFF_FFFC);
        apply_stimulus(SEL_SEQ, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        expect_at(K_PC4, cyc, 32'h0);
        expect_at(K_PC, cyc + 1, 32'h0);
        tick();

        // Five calls into a 4-deep stack, then five returns
        set_pc(32'h10);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] tgt;
            tgt = (i < 4) ? 32'(16 * (i + 2)) : 32'h200;
            apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, tgt, 1'b1, 1'b0, 1'b0);
            expect_at(K_PC, cyc + 1, tgt);
            if (i == 0) expect_at(K_EMPTY, cyc + 1, 32'd0);
            if (i == 2) expect_at(K_FULL, cyc + 1, 32'd0);
            if (i >= 3) expect_at(K_FULL, cyc + 1, 32'd1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, 32'hDEAD_BEE0, 1'b0, 1'b1, 1'b0);
            expect_at(K_PC, cyc + 1, pop_seq[i]);
            if (i == 2) expect_at(K_EMPTY, cyc + 1, 32'd0);
            if (i >= 3) expect_at(K_EMPTY, cyc + 1, 32'd1);
            tick();
        end

        // Stall freezes pc and the stack, then a misaligned register jump
        set_pc(32'h100);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(SEL_JUMP, 1'b0, 32'd0, 26'h40, 32'd0, 1'b1, 1'b0, 1'b1);
            expect_at(K_PC, cyc + 1, 32'h100);
            expect_at(K_EMPTY, cyc + 1, 32'd1);
            tick();
        end
        apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, 32'h103, 1'b0, 1'b0, 1'b0);
        expect_at(K_MIS, cyc, 32'd1);
        expect_at(K_NPC, cyc, 32'h100);
        expect_at(K_PC, cyc + 1, 32'h100);
        tick();

        // Pop ignored outside JR; push+pop replaces the top
        apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, 32'h300, 1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(SEL_SEQ, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        expect_at(K_PC, cyc + 1, 32'h304);
        expect_at(K_EMPTY, cyc + 1, 32'd0);
        tick();
        apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, 32'hDEAD_BEE0, 1'b1, 1'b1, 1'b0);
        expect_at(K_PC, cyc + 1, 32'h104);
        expect_at(K_EMPTY, cyc + 1, 32'd0);
        tick();
        apply_stimulus(SEL_JR, 1'b0, 32'd0, 26'd0, 32'h500, 1'b0, 1'b1, 1'b0);
        expect_at(K_PC, cyc + 1, 32'h308);
        expect_at(K_EMPTY, cyc + 1, 32'd1);
        tick();

        // Asynchronous reset mid-cycle with two stacked entries
        apply_stimulus(SEL_SEQ, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        apply_stimulus(SEL_SEQ, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        expect_at(K_EMPTY, cyc, 32'd0);
        tick();
        #1;
        reset = 1'b1;
        expect_at(K_PC, cyc, RV);
        expect_at(K_EMPTY, cyc, 32'd1);
        tick();
        reset = 1'b0;
        apply_stimulus(SEL_SEQ, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        expect_at(K_PC, cyc, RV);
        expect_at(K_PC, cyc + 1, RV + 32'd4);
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_count++;
            $display("[TB] FAIL %s: expectation for cycle %0d never checked, expected %h",
                     name_of(e.kind), e.cycle, e.value);
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the address width (≥ 30).
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack entry count (power of 2, ≥ 2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 stall  input  1  SHALL, when high, hold pc and RAS.
REQ-007 pc_mux_sel  input  2  SHALL select the next-PC source: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR.
REQ-008 branch_taken  input  1  SHALL qualify BRANCH.
REQ-009 imm_offset  input  XLEN  SHALL be the sign-extended branch word offset.
REQ-010 jump_index  input  26  SHALL be the J-type instruction index.
REQ-011 jr_target  input  XLEN  SHALL be the register-file jump address.
REQ-012 ras_push  input  1  SHALL push pc_plus_4 (call).
REQ-013 ras_pop  input  1  SHALL pop the RAS (return); meaningful only with JR.
REQ-014 pc  output  XLEN  SHALL be the current program counter (registered).
REQ-015 pc_plus_4, branch_target, jump_target, next_pc  output  XLEN each  SHALL be combinational from pc and inputs.
REQ-016 ras_empty, ras_full  output  1 each  SHALL give the RAS occupancy state (registered).
REQ-017 misaligned  output  1  SHALL flag a selected target with bits [1:0] ≠ 0 (combinational).

Function
REQ-018 pc_plus_4 SHALL equal pc + 4, modulo 2^XLEN (wraps from all-ones-minus-3 to 0).
REQ-019 branch_target SHALL equal pc_plus_4 + (imm_offset << 2), modulo 2^XLEN.
REQ-020 jump_target SHALL equal {pc_plus_4[XLEN-1:28], jump_index, 2'b00}.
REQ-021 Raw target SHALL be: SEQ pc_plus_4; BRANCH branch_taken ? branch_target : pc_plus_4; JUMP jump_target; JR (ras_pop && !ras_empty) ? RAS top : jr_target.
REQ-022 next_pc SHALL equal the raw target with bits [1:0] forced to 00; misaligned SHALL be high when raw target bits [1:0] ≠ 00.
REQ-023 When stall is low, pc SHALL load next_pc at the next rising edge (one-cycle latency); when stall is high, pc SHALL hold.
REQ-024 The RAS SHALL be circular with a pointer and a count saturating at RAS_DEPTH; it SHALL update only when stall is low.
REQ-025 Push when not full SHALL write pc_plus_4 at the new top and increment count.
REQ-026 Push when full SHALL overwrite the oldest entry; count stays at RAS_DEPTH.
REQ-027 Pop when empty SHALL be a no-op, with JR using jr_target.
REQ-028 Simultaneous push and pop when not empty SHALL replace the top with pc_plus_4, count unchanged; when empty, push only.
REQ-029 ras_pop with pc_mux_sel ≠ JR SHALL be ignored.

Reset
REQ-030 Reset SHALL immediately set pc to RESET_VECTOR, RAS count and pointer to 0, ras_empty to 1, and ras_full to 0; RAS entry contents SHALL be don't-care.
REQ-031 Reset asserted mid-operation, including during stall, SHALL override all other inputs; the first post-reset edge SHALL load next_pc computed from RESET_VECTOR.

Structure
REQ-032 Shared package pc_pkg SHALL hold the pc_mux_sel encodings (SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JR) and the value 4 as the increment constant.
REQ-033 The RAS SHALL be a sub-module pc_ras (parameters XLEN, RAS_DEPTH; ports push, pop, din, top, empty, full).

Verification
REQ-034 Reset with RESET_VECTOR = 0x0040_0000, then 3 SEQ cycles -> pc = 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C.
REQ-035 pc = 0x100, BRANCH, branch_taken = 1, imm_offset = 0xFFFF_FFFE -> next pc = 0x0FC; with branch_taken = 0 -> 0x104.
REQ-036 pc = 0x9000_0010, JUMP, jump_index = 0x0000_040 -> next pc = 0x9000_0100; pc = 0xFFFF_FFFC, SEQ -> next pc = 0x0000_0000.
REQ-037 Five pushes at pc = 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH = 4), then 5 pops with JR and jr_target = 0xDEAD_BEE0 -> pc sequence 0x54, 0x44, 0x34, 0x24, 0xDEAD_BEE0; ras_full high after the 4th push; ras_empty high after the 4th pop.
REQ-038 Stall high for 3 cycles with JUMP and ras_push -> pc and RAS count unchanged; JR with jr_target = 0x103 -> pc = 0x100 and misaligned = 1.
REQ-039 Reset asserted asynchronously mid-cycle with RAS holding 2 entries -> pc = RESET_VECTOR before the next edge and ras_empty = 1.
